vm_credit_ledger: RTL and testbench

Parametrised credit accumulator and vend sequencer for the vending-machine datapath, sitting between the coin acceptor and the dispense/change units. It accumulates validated coin values with overflow rejection and checks a selected product against a per-product price table. It issues a vend request with a ready/valid handshake, then returns change or a full refund. Refunds happen on cancel or on an internal inactivity timeout.

---
 rtl/vm_pkg.sv | 22 ++
 rtl/vm_idle_timer.sv | 35 +++
 rtl/vm_credit_ledger.sv | 183 ++++++++++++++++++
 tb/tb_vm_credit_ledger.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine credit ledger: state encoding,
// default datapath width and the price-table slicing helper.
`default_nettype none

package vm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } vm_state_e;

   localparam int c_CREDIT_W_DEFAULT = 8;

   function automatic int unsigned price_lsb(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vm_idle_timer.sv
// Inactivity timer: counts enabled, uncleared cycles and flags the cycle in
// which the count sits at TIMEOUT_CYC-1.
`default_nettype none

module vm_idle_timer #(
   parameter  int TIMEOUT_CYC = 1000,
   localparam int CNT_W       = $clog2(TIMEOUT_CYC)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_cnt;

   // A clear in the terminal cycle wins, so activity always restarts the window.
   assign o_expire = i_en && !i_clr && (r_cnt == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || !i_en || (r_cnt == c_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/vm_credit_ledger.sv
// Credit accumulator and vend sequencer: collects coins, checks a selection
// against the price table, hands off the vend and returns change or refund.
`default_nettype none

module vm_credit_ledger
   import vm_pkg::*;
#(
   parameter  int CREDIT_W    = c_CREDIT_W_DEFAULT,
   parameter  int N_PROD      = 4,
   parameter  int MAX_CREDIT  = 2**CREDIT_W - 1,
   parameter  int TIMEOUT_CYC = 1000,
   localparam int SEL_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_coin_valid,
   input  logic [CREDIT_W-1:0]        i_coin_value,
   input  logic                       i_sel_valid,
   input  logic [SEL_W-1:0]           i_sel_idx,
   input  logic                       i_cancel,
   input  logic [N_PROD*CREDIT_W-1:0] i_prices,
   input  logic                       i_vend_ready,
   input  logic                       i_change_ready,
   output logic [CREDIT_W-1:0]        o_credit,
   output logic                       o_coin_reject,
   output logic                       o_sel_reject,
   output logic                       o_timeout,
   output logic                       o_vend_valid,
   output logic [SEL_W-1:0]           o_vend_idx,
   output logic                       o_change_valid,
   output logic [CREDIT_W-1:0]        o_change_amt,
   output logic                       o_busy
);

   vm_state_e           r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] r_price;
   logic [CREDIT_W-1:0] r_change_amt;
   logic [SEL_W-1:0]    r_vend_idx;
   logic                r_coin_reject;
   logic                r_sel_reject;
   logic                r_timeout;
   logic                r_vend_valid;
   logic                r_change_valid;
   logic                r_busy;

   logic [CREDIT_W:0]   w_sum;
   logic                w_coin_ok;
   logic                w_sel_in_range;
   logic                w_sel_ok;
   logic [SEL_W-1:0]    w_sel_safe;
   logic [CREDIT_W-1:0] w_price;
   logic [CREDIT_W-1:0] w_remainder;
   logic                w_in_collect;
   logic                w_timer_clr;
   logic                w_expire;
   logic [CREDIT_W-1:0] w_price_tbl [N_PROD];

   for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
      assign w_price_tbl[gi] = i_prices[price_lsb(gi, CREDIT_W) +: CREDIT_W];
   end

   // One extra bit on the sum so a wrapping coin is still seen as overflow.
   assign w_sum          = {1'b0, r_credit} + {1'b0, i_coin_value};
   assign w_coin_ok      = (i_coin_value != '0) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
   assign w_sel_in_range = 32'(i_sel_idx) < 32'(N_PROD);
   assign w_sel_safe     = w_sel_in_range ? i_sel_idx : '0;
   assign w_price        = w_price_tbl[w_sel_safe];
   assign w_sel_ok       = w_sel_in_range && (r_credit >= w_price);
   assign w_remainder    = r_credit - r_price;

   assign w_in_collect = (r_state == COLLECT);
   assign w_timer_clr  = !w_in_collect || i_coin_valid || i_sel_valid;

   vm_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (w_in_collect),
      .i_clr    (w_timer_clr),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_credit       <= '0;
         r_price        <= '0;
         r_change_amt   <= '0;
         r_vend_idx     <= '0;
         r_coin_reject  <= 1'b0;
         r_sel_reject   <= 1'b0;
         r_timeout      <= 1'b0;
         r_vend_valid   <= 1'b0;
         r_change_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_coin_reject <= 1'b0;
         r_sel_reject  <= 1'b0;
         r_timeout     <= 1'b0;
         case (r_state)
            IDLE: begin
               r_sel_reject <= i_sel_valid;
               if (i_coin_valid) begin
                  if (w_coin_ok) begin
                     r_credit <= w_sum[CREDIT_W-1:0];
                     r_state  <= COLLECT;
                  end else begin
                     r_coin_reject <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               // Cancel and expiry share one refund path; a coin losing priority is bounced.
               if (i_cancel || w_expire) begin
                  r_change_amt   <= r_credit;
                  r_change_valid <= 1'b1;
                  r_busy         <= 1'b1;
                  r_timeout      <= w_expire;
                  r_coin_reject  <= i_coin_valid;
                  r_state        <= CHANGE;
               end else if (i_sel_valid) begin
                  r_coin_reject <= i_coin_valid;
                  if (w_sel_ok) begin
                     r_vend_idx   <= i_sel_idx;
                     r_price      <= w_price;
                     r_vend_valid <= 1'b1;
                     r_busy       <= 1'b1;
                     r_state      <= VEND;
                  end else begin
                     r_sel_reject <= 1'b1;
                  end
               end else if (i_coin_valid) begin
                  if (w_coin_ok) begin
                     r_credit <= w_sum[CREDIT_W-1:0];
                  end else begin
                     r_coin_reject <= 1'b1;
                  end
               end
            end
            VEND: begin
               r_coin_reject <= i_coin_valid;
               if (i_vend_ready) begin
                  r_vend_valid <= 1'b0;
                  if (w_remainder != '0) begin
                     r_change_amt   <= w_remainder;
                     r_change_valid <= 1'b1;
                     r_state        <= CHANGE;
                  end else begin
                     r_credit <= '0;
                     r_busy   <= 1'b0;
                     r_state  <= IDLE;
                  end
               end
            end
            CHANGE: begin
               r_coin_reject <= i_coin_valid;
               if (i_change_ready) begin
                  r_change_valid <= 1'b0;
                  r_credit       <= '0;
                  r_busy         <= 1'b0;
                  r_state        <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_credit       = r_credit;
   assign o_coin_reject  = r_coin_reject;
   assign o_sel_reject   = r_sel_reject;
   assign o_timeout      = r_timeout;
   assign o_vend_valid   = r_vend_valid;
   assign o_vend_idx     = r_vend_idx;
   assign o_change_valid = r_change_valid;
   assign o_change_amt   = r_change_amt;
   assign o_busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vm_credit_ledger.sv
// Scoreboard bench for vm_credit_ledger: a transaction-level model predicts
// every cycle's outputs and each vend/change transfer; a monitor compares.
`default_nettype none

module tb_vm_credit_ledger;

   localparam int CW = 8;
   localparam int NP = 4;
   localparam int T  = 20;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           i_coin_valid = 1'b0;
   logic [CW-1:0]  i_coin_value = '0;
   logic           i_sel_valid = 1'b0;
   logic [1:0]     i_sel_idx = '0;
   logic           i_cancel = 1'b0;
   logic [NP*CW-1:0] i_prices;
   logic           i_vend_ready = 1'b0;
   logic           i_change_ready = 1'b0;
   logic [CW-1:0]  o_credit;
   logic           o_coin_reject;
   logic           o_sel_reject;
   logic           o_timeout;
   logic           o_vend_valid;
   logic [1:0]     o_vend_idx;
   logic           o_change_valid;
   logic [CW-1:0]  o_change_amt;
   logic           o_busy;

   vm_credit_ledger #(
      .CREDIT_W    (CW),
      .N_PROD      (NP),
      .MAX_CREDIT  (255),
      .TIMEOUT_CYC (T)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_coin_valid   (i_coin_valid),
      .i_coin_value   (i_coin_value),
      .i_sel_valid    (i_sel_valid),
      .i_sel_idx      (i_sel_idx),
      .i_cancel       (i_cancel),
      .i_prices       (i_prices),
      .i_vend_ready   (i_vend_ready),
      .i_change_ready (i_change_ready),
      .o_credit       (o_credit),
      .o_coin_reject  (o_coin_reject),
      .o_sel_reject   (o_sel_reject),
      .o_timeout      (o_timeout),
      .o_vend_valid   (o_vend_valid),
      .o_vend_idx     (o_vend_idx),
      .o_change_valid (o_change_valid),
      .o_change_amt   (o_change_amt),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] credit;
      logic       coin_rej;
      logic       sel_rej;
      logic       tmo;
      logic       vv;
      logic [1:0] vidx;
      logic       cv;
      logic [7:0] camt;
      logic       busy;
   } snap_t;

   snap_t exp_q[$];
   int    vq[$];
   int    cq[$];
   int    checks = 0;
   int    failures = 0;
   bit    mon_on = 1'b0;

   // Model: held credit, pending vend product (-1 none), its price,
   // pending change amount (0 none) and idle cycles spent collecting.
   int m_credit, m_vend, m_vprice, m_change, m_idle;
   int price[NP] = '{10, 25, 40, 5};

   function automatic snap_t mk_snap(input bit cr, input bit sr, input bit to);
      snap_t s;
      s.credit   = 8'(m_credit);
      s.coin_rej = cr;
      s.sel_rej  = sr;
      s.tmo      = to;
      s.vv       = (m_vend >= 0);
      s.vidx     = (m_vend >= 0) ? 2'(m_vend) : 2'd0;
      s.cv       = (m_change > 0);
      s.camt     = 8'(m_change);
      s.busy     = (m_vend >= 0) || (m_change > 0);
      return s;
   endfunction

   task automatic model_reset();
      m_credit = 0; m_vend = -1; m_vprice = 0; m_change = 0; m_idle = 0;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Drive one cycle of inputs, predict the outcome, then advance one clock.
   task automatic step(input bit cv, input int val, input bit sv, input int si,
                       input bit can, input bit vr, input bit crd);
      bit cr = 1'b0;
      bit sr = 1'b0;
      bit to = 1'b0;
      bit expire;
      int rem;
      i_coin_valid = cv; i_coin_value = 8'(val); i_sel_valid = sv; i_sel_idx = 2'(si);
      i_cancel = can; i_vend_ready = vr; i_change_ready = crd;
      if (m_vend >= 0 && vr) vq.push_back(m_vend);
      if (m_change > 0 && crd) cq.push_back(m_change);
      if (m_vend >= 0) begin
         cr = cv;
         if (vr) begin
            rem = m_credit - m_vprice;
            if (rem > 0) m_change = rem; else m_credit = 0;
            m_vend = -1;
         end
      end else if (m_change > 0) begin
         cr = cv;
         if (crd) begin m_change = 0; m_credit = 0; end
      end else if (m_credit == 0) begin
         sr = sv;
         if (cv) begin
            if (val != 0 && m_credit + val <= 255) begin m_credit += val; m_idle = 0; end
            else cr = 1'b1;
         end
      end else begin
         expire = (m_idle == T - 1) && !cv && !sv;
         if (cv || sv) m_idle = 0; else m_idle++;
         if (can || expire) begin
            m_change = m_credit; to = expire; cr = cv;
         end else if (sv) begin
            cr = cv;
            if (si < NP && m_credit >= price[si]) begin m_vend = si; m_vprice = price[si]; end
            else sr = 1'b1;
         end else if (cv) begin
            if (val != 0 && m_credit + val <= 255) m_credit += val; else cr = 1'b1;
         end
      end
      exp_q.push_back(mk_snap(cr, sr, to));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input bit vr, input bit crd);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, vr, crd);
   endtask

   // Asserts reset between clock edges and checks outputs before any edge.
   task automatic async_reset(input string tag);
      mon_on = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_credit"}, int'(o_credit), 0);
      chk({tag, "_pulses"}, int'({o_coin_reject, o_sel_reject, o_timeout}), 0);
      chk({tag, "_vend_valid"}, int'(o_vend_valid), 0);
      chk({tag, "_vend_idx"}, int'(o_vend_idx), 0);
      chk({tag, "_change"}, int'({o_change_valid, o_change_amt}), 0);
      chk({tag, "_busy"}, int'(o_busy), 0);
      exp_q.delete(); vq.delete(); cq.delete();
      model_reset();
      i_coin_valid = 0; i_sel_valid = 0; i_cancel = 0; i_vend_ready = 0; i_change_ready = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.push_back(mk_snap(0, 0, 0));
      mon_on = 1'b1;
   endtask

   snap_t mon_a, mon_e;
   int    mon_x;

   always @(negedge clk) begin
      if (mon_on) begin
         mon_a = '{credit: o_credit, coin_rej: o_coin_reject, sel_rej: o_sel_reject,
                   tmo: o_timeout, vv: o_vend_valid, vidx: (o_vend_valid ? o_vend_idx : 2'd0),
                   cv: o_change_valid, camt: (o_change_valid ? o_change_amt : 8'd0), busy: o_busy};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL outputs t=%0t: actual=%h required=<none queued>", $time, mon_a);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a !== mon_e) begin
               failures++;
               $display("FAIL outputs t=%0t: actual credit=%0d crej=%b srej=%b tmo=%b vv=%b vidx=%0d cv=%b camt=%0d busy=%b required credit=%0d crej=%b srej=%b tmo=%b vv=%b vidx=%0d cv=%b camt=%0d busy=%b",
                        $time, mon_a.credit, mon_a.coin_rej, mon_a.sel_rej, mon_a.tmo, mon_a.vv, mon_a.vidx, mon_a.cv, mon_a.camt, mon_a.busy,
                        mon_e.credit, mon_e.coin_rej, mon_e.sel_rej, mon_e.tmo, mon_e.vv, mon_e.vidx, mon_e.cv, mon_e.camt, mon_e.busy);
            end
         end
         if (o_vend_valid && i_vend_ready) begin
            checks++;
            if (vq.size() == 0) begin
               failures++;
               $display("FAIL vend_xfer t=%0t: actual idx=%0d required=<no transfer>", $time, o_vend_idx);
            end else begin
               mon_x = vq.pop_front();
               if (o_vend_idx !== 2'(mon_x)) begin
                  failures++;
                  $display("FAIL vend_xfer t=%0t: actual idx=%0d required idx=%0d", $time, o_vend_idx, mon_x);
               end
            end
         end
         if (o_change_valid && i_change_ready) begin
            checks++;
            if (cq.size() == 0) begin
               failures++;
               $display("FAIL change_xfer t=%0t: actual amt=%0d required=<no transfer>", $time, o_change_amt);
            end else begin
               mon_x = cq.pop_front();
               if (o_change_amt !== 8'(mon_x)) begin
                  failures++;
                  $display("FAIL change_xfer t=%0t: actual amt=%0d required amt=%0d", $time, o_change_amt, mon_x);
               end
            end
         end
      end
   end

   int quiet;
   int cval;

   initial begin
      i_prices = {8'(price[3]), 8'(price[2]), 8'(price[1]), 8'(price[0])};
      model_reset();
      async_reset("reset");

      // Vend with change: 20 + 10, select product 1 (25), change 5.
      step(1, 20, 0, 0, 0, 0, 0);
      step(1, 10, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      idle(2, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      idle(2, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      idle(2, 1, 1);

      // Overflow reject at 250, then refund by cancel.
      step(1, 200, 0, 0, 0, 0, 0);
      step(1, 50, 0, 0, 0, 0, 0);
      step(1, 10, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);

      // Insufficient credit, then exact-price vend with no change.
      step(1, 15, 0, 0, 0, 0, 0);
      step(0, 0, 1, 2, 0, 0, 0);
      step(1, 25, 0, 0, 0, 0, 0);
      step(0, 0, 1, 2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      idle(2, 1, 1);

      // Inactivity timeout refund, change held off for a while.
      step(1, 7, 0, 0, 0, 0, 0);
      idle(T + 6, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);

      // Simultaneous cancel, select and coin at credit 30.
      step(1, 30, 0, 0, 0, 0, 0);
      step(1, 5, 1, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      idle(1, 0, 0);

      // Select in IDLE is rejected; reset during a pending vend.
      step(0, 0, 1, 3, 0, 0, 0);
      step(1, 20, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("vend_pending_before_reset", int'(o_vend_valid), 1);
      async_reset("reset_in_vend");
      step(1, 5, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(1, 0, 0);

      quiet = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) async_reset("reset_random");
         if (quiet > 0) begin
            quiet--;
            step(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            if ($urandom_range(0, 99) < 3) quiet = int'($urandom_range(5, T + 5));
            case ($urandom_range(0, 7))
               0: cval = 0;
               1: cval = 1;
               2: cval = 5;
               3: cval = 10;
               4: cval = 25;
               5: cval = 100;
               6: cval = 200;
               default: cval = int'($urandom_range(0, 255));
            endcase
            step(1'($urandom_range(0, 99) < 35), cval,
                 1'($urandom_range(0, 99) < 12), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 40));
         end
      end

      idle(4, 1, 1);
      @(negedge clk); #1;
      mon_on = 1'b0;
      chk("queue_drain_outputs", exp_q.size(), 0);
      chk("queue_drain_vend", vq.size(), 0);
      chk("queue_drain_change", cq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
